// File: rtl/ar_cluster_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ar_cluster_scheduler_pkg
// Description : Shared types for the cluster AXI read scheduler: AR and R
//               channel payloads and the per-request cluster metadata.
// Revision    : 1.0 - initial release
// ============================================================================
package ar_cluster_scheduler_pkg;

    localparam int unsigned DEFAULT_NR_REQ          = 4;
    localparam int unsigned DEFAULT_MAX_OUTSTANDING = 8;

    // AR channel payload
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_chan_t;

    // R channel payload; .last closes a burst and releases its route entry
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    // Metadata travelling alongside each AR towards the alignment stage
    typedef struct packed {
        logic [3:0]  cluster_id;
        logic [15:0] tag;
        logic [2:0]  elem_width;
    } cluster_metadata_t;

endpackage : ar_cluster_scheduler_pkg
`default_nettype wire

// File: rtl/ar_cluster_scheduler_route_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ar_cluster_scheduler_route_fifo
// Description : Route FIFO holding the requester index of every in-flight AR
//               burst. Full/empty derive from the registered count, so a pop
//               never frees a slot for a push in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ar_cluster_scheduler_route_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);
    assign data_o    = mem_q[rd_ptr_q];
    assign w_push_ok = push_i & ~full_o;
    assign w_pop_ok  = pop_i & ~empty_o;

    // Next-state pointers and occupancy; pointers wrap explicitly at DEPTH-1
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (w_pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers, cleared by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : ar_cluster_scheduler_route_fifo
`default_nettype wire

// File: rtl/ar_cluster_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ar_cluster_scheduler
// Description : Shares one system AXI read port among NR_REQ cluster
//               requesters. Round-robin AR arbitration with grant lock while
//               the system stalls; R beats are routed back in order through a
//               FIFO of requester indices.
// Revision    : 1.0 - initial release
// ============================================================================
module ar_cluster_scheduler
    import ar_cluster_scheduler_pkg::*;
#(
    parameter int unsigned NR_REQ          = DEFAULT_NR_REQ,
    parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter type         axi_ar_t        = ar_chan_t,
    parameter type         axi_r_t         = r_chan_t,
    parameter type         meta_t          = cluster_metadata_t
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  axi_ar_t           req_ar_i       [NR_REQ],
    input  meta_t             req_meta_i     [NR_REQ],
    input  logic [NR_REQ-1:0] req_ar_valid_i,
    output logic [NR_REQ-1:0] req_ar_ready_o,
    output axi_r_t            req_r_o        [NR_REQ],
    output logic [NR_REQ-1:0] req_r_valid_o,
    input  logic [NR_REQ-1:0] req_r_ready_i,
    output axi_ar_t           ar_o,
    output meta_t             meta_o,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    input  axi_r_t            r_i,
    input  logic              r_valid_i,
    output logic              r_ready_o
);

    localparam int unsigned IDX_W = $clog2(NR_REQ);
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NR_REQ - 1);

    idx_t ptr_q, ptr_d;
    logic lock_q, lock_d;
    idx_t lock_idx_q, lock_idx_d;

    idx_t w_rr_idx;
    idx_t w_grant;
    idx_t w_head;
    logic w_full;
    logic w_empty;
    logic w_ar_hs;
    logic w_pop;

    // Round-robin pick: first valid requester at or after the pointer
    always_comb begin : rr_pick
        int unsigned cand;
        logic        found;
        w_rr_idx = ptr_q;
        found    = 1'b0;
        cand     = 0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NR_REQ) begin
                cand = cand - NR_REQ;
            end
            if (!found && req_ar_valid_i[idx_t'(cand)]) begin
                found    = 1'b1;
                w_rr_idx = idx_t'(cand);
            end
        end
    end

    // A stalled AR keeps its winner so the payload cannot change under the system
    assign w_grant    = lock_q ? lock_idx_q : w_rr_idx;
    assign ar_valid_o = rst_ni & (|req_ar_valid_i) & ~w_full;
    assign ar_o       = req_ar_i[w_grant];
    assign meta_o     = req_meta_i[w_grant];
    assign w_ar_hs    = ar_valid_o & ar_ready_i;

    // Only the routed lane sees R valid; the R payload is broadcast to all lanes
    assign r_ready_o = req_r_ready_i[w_head] & ~w_empty;
    assign w_pop     = r_valid_i & r_ready_o & r_i.last;

    for (genvar g = 0; g < NR_REQ; g++) begin : g_lane
        assign req_ar_ready_o[g] = (w_grant == idx_t'(g)) & ar_valid_o & ar_ready_i;
        assign req_r_valid_o[g]  = (w_head == idx_t'(g)) & r_valid_i & ~w_empty;
        assign req_r_o[g]        = r_i;
    end

    // Pointer advances past the winner on handshake; lock tracks an unaccepted AR
    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (w_ar_hs) begin
            ptr_d  = (w_grant == LAST_IDX) ? '0 : w_grant + idx_t'(1);
            lock_d = 1'b0;
        end else if (ar_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = w_grant;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    ar_cluster_scheduler_route_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_ar_hs),
        .data_i  (w_grant),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

endmodule : ar_cluster_scheduler
`default_nettype wire

// File: tb/tb_ar_cluster_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ar_cluster_scheduler
// Description : Self-checking bench for ar_cluster_scheduler: directed
//               scenarios plus randomized traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ar_cluster_scheduler;
    import ar_cluster_scheduler_pkg::*;

    localparam int NR = 4;
    localparam int MO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    ar_chan_t          req_ar      [NR];
    cluster_metadata_t req_meta    [NR];
    logic [NR-1:0]     req_ar_valid;
    logic [NR-1:0]     req_ar_ready;
    r_chan_t           req_r       [NR];
    logic [NR-1:0]     req_r_valid;
    logic [NR-1:0]     req_r_ready;
    ar_chan_t          ar;
    cluster_metadata_t meta;
    logic              ar_valid;
    logic              ar_ready;
    r_chan_t           r;
    logic              r_valid;
    logic              r_ready;

    int n_vec = 0;
    int n_err = 0;

    ar_cluster_scheduler #(
        .NR_REQ          (NR),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_ar_i       (req_ar),
        .req_meta_i     (req_meta),
        .req_ar_valid_i (req_ar_valid),
        .req_ar_ready_o (req_ar_ready),
        .req_r_o        (req_r),
        .req_r_valid_o  (req_r_valid),
        .req_r_ready_i  (req_r_ready),
        .ar_o           (ar),
        .meta_o         (meta),
        .ar_valid_o     (ar_valid),
        .ar_ready_i     (ar_ready),
        .r_i            (r),
        .r_valid_i      (r_valid),
        .r_ready_o      (r_ready)
    );

    initial forever #5 clk = ~clk;

    function automatic ar_chan_t rand_ar();
        ar_chan_t a;
        a.id    = 4'($urandom);
        a.addr  = $urandom;
        a.len   = 8'($urandom);
        a.size  = 3'($urandom);
        a.burst = 2'($urandom);
        return a;
    endfunction

    function automatic cluster_metadata_t rand_meta();
        cluster_metadata_t m;
        m.cluster_id = 4'($urandom);
        m.tag        = 16'($urandom);
        m.elem_width = 3'($urandom);
        return m;
    endfunction

    function automatic r_chan_t rand_r(input logic last);
        r_chan_t b;
        b.id   = 4'($urandom);
        b.data = $urandom;
        b.resp = 2'($urandom);
        b.last = last;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NR; i++) begin
            req_ar[i]   = rand_ar();
            req_meta[i] = rand_meta();
        end
        req_ar_valid = '0;
        req_r_ready  = '1;
        ar_ready     = 1'b0;
        r            = rand_r(1'b0);
        r_valid      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n        = 1'b0;
        req_ar_valid = '1;
        ar_ready     = 1'b1;
        r_valid      = 1'b1;
        @(negedge clk);
        n_vec += 4;
        if (ar_valid !== 1'b0) begin n_err++; $display("FAIL reset_ar_valid: got %b expected 0", ar_valid); end
        if (req_ar_ready !== 4'b0) begin n_err++; $display("FAIL reset_ar_ready: got %b expected 0000", req_ar_ready); end
        if (req_r_valid !== 4'b0) begin n_err++; $display("FAIL reset_r_valid: got %b expected 0000", req_r_valid); end
        if (r_ready !== 1'b0) begin n_err++; $display("FAIL reset_r_ready: got %b expected 0", r_ready); end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_ar[0].len = 8'd3;
        req_ar_valid  = 4'b0001;
        ar_ready      = 1'b1;
        @(negedge clk);
        n_vec += 4;
        if (ar_valid !== 1'b1) begin n_err++; $display("FAIL single_ar_valid: got %b expected 1", ar_valid); end
        if (ar !== req_ar[0]) begin n_err++; $display("FAIL single_ar: got %h expected %h", ar, req_ar[0]); end
        if (meta !== req_meta[0]) begin n_err++; $display("FAIL single_meta: got %h expected %h", meta, req_meta[0]); end
        if (req_ar_ready !== 4'b0001) begin n_err++; $display("FAIL single_ar_ready: got %b expected 0001", req_ar_ready); end
        tick();
        req_ar_valid = '0;
        for (int b = 0; b < 4; b++) begin
            r       = rand_r(b == 3);
            r_valid = 1'b1;
            @(negedge clk);
            n_vec += 3;
            if (req_r_valid !== 4'b0001) begin n_err++; $display("FAIL single_r_valid beat %0d: got %b expected 0001", b, req_r_valid); end
            if (r_ready !== 1'b1) begin n_err++; $display("FAIL single_r_ready beat %0d: got %b expected 1", b, r_ready); end
            if (req_r[0] !== r) begin n_err++; $display("FAIL single_r_data beat %0d: got %h expected %h", b, req_r[0], r); end
            tick();
        end
        r = rand_r(1'b1);
        @(negedge clk);
        n_vec += 2;
        if (r_ready !== 1'b0) begin n_err++; $display("FAIL single_empty_r_ready: got %b expected 0", r_ready); end
        if (req_r_valid !== 4'b0) begin n_err++; $display("FAIL single_empty_r_valid: got %b expected 0000", req_r_valid); end
        r_valid = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_v;
        do_reset();
        req_ar_valid = '1;
        ar_ready     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_v = '0;
            exp_v[k % NR] = 1'b1;
            @(negedge clk);
            n_vec += 2;
            if (req_ar_ready !== exp_v) begin n_err++; $display("FAIL rr_grant %0d: got %b expected %b", k, req_ar_ready, exp_v); end
            if (ar !== req_ar[k % NR]) begin n_err++; $display("FAIL rr_ar %0d: got %h expected %h", k, ar, req_ar[k % NR]); end
            tick();
        end
        req_ar_valid = '0;
        for (int k = 0; k < 5; k++) begin
            exp_v = '0;
            exp_v[k % NR] = 1'b1;
            r       = rand_r(1'b1);
            r_valid = 1'b1;
            @(negedge clk);
            n_vec++;
            if (req_r_valid !== exp_v) begin n_err++; $display("FAIL rr_route %0d: got %b expected %b", k, req_r_valid, exp_v); end
            tick();
        end
        r_valid = 1'b0;
    endtask

    task automatic test_stall_lock();
        do_reset();
        req_ar_valid = 4'b0010;
        ar_ready     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_ar_valid = 4'b0011;
            @(negedge clk);
            n_vec += 4;
            if (ar_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid c%0d: got %b expected 1", c, ar_valid); end
            if (ar !== req_ar[1]) begin n_err++; $display("FAIL stall_ar c%0d: got %h expected %h", c, ar, req_ar[1]); end
            if (meta !== req_meta[1]) begin n_err++; $display("FAIL stall_meta c%0d: got %h expected %h", c, meta, req_meta[1]); end
            if (req_ar_ready !== 4'b0) begin n_err++; $display("FAIL stall_ready c%0d: got %b expected 0000", c, req_ar_ready); end
            tick();
        end
        ar_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ar_ready !== 4'b0010) begin n_err++; $display("FAIL stall_first: got %b expected 0010", req_ar_ready); end
        tick();
        req_ar_valid = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (req_ar_ready !== 4'b0001) begin n_err++; $display("FAIL stall_second: got %b expected 0001", req_ar_ready); end
        tick();
        req_ar_valid = '0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        req_ar_valid = '1;
        ar_ready     = 1'b1;
        for (int k = 0; k < MO; k++) begin
            @(negedge clk);
            n_vec++;
            if (ar_valid !== 1'b1) begin n_err++; $display("FAIL full_fill %0d: got %b expected 1", k, ar_valid); end
            tick();
        end
        @(negedge clk);
        n_vec += 2;
        if (ar_valid !== 1'b0) begin n_err++; $display("FAIL full_ar_valid: got %b expected 0", ar_valid); end
        if (req_ar_ready !== 4'b0) begin n_err++; $display("FAIL full_ar_ready: got %b expected 0000", req_ar_ready); end
        tick();
        r       = rand_r(1'b1);
        r_valid = 1'b1;
        @(negedge clk);
        n_vec += 3;
        if (r_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_r_ready: got %b expected 1", r_ready); end
        if (req_r_valid !== 4'b0001) begin n_err++; $display("FAIL full_pop_route: got %b expected 0001", req_r_valid); end
        if (ar_valid !== 1'b0) begin n_err++; $display("FAIL full_pop_same_cycle: got %b expected 0", ar_valid); end
        tick();
        r_valid = 1'b0;
        @(negedge clk);
        n_vec += 2;
        if (ar_valid !== 1'b1) begin n_err++; $display("FAIL full_after_pop_valid: got %b expected 1", ar_valid); end
        if (req_ar_ready !== 4'b0001) begin n_err++; $display("FAIL full_after_pop_ready: got %b expected 0001", req_ar_ready); end
        tick();
        req_ar_valid = '0;
    endtask

    task automatic test_r_stall();
        do_reset();
        req_ar_valid = 4'b0100;
        ar_ready     = 1'b1;
        tick();
        req_ar_valid = '0;
        r            = rand_r(1'b1);
        r_valid      = 1'b1;
        req_r_ready  = 4'b1011;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec += 2;
            if (r_ready !== 1'b0) begin n_err++; $display("FAIL rstall_ready c%0d: got %b expected 0", c, r_ready); end
            if (req_r_valid !== 4'b0100) begin n_err++; $display("FAIL rstall_lanes c%0d: got %b expected 0100", c, req_r_valid); end
            tick();
        end
        req_r_ready = '1;
        @(negedge clk);
        n_vec++;
        if (r_ready !== 1'b1) begin n_err++; $display("FAIL rstall_release: got %b expected 1", r_ready); end
        tick();
        r_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_ar[1].len = 8'd3;
        req_ar_valid  = 4'b0010;
        ar_ready      = 1'b1;
        tick();
        req_ar_valid = '0;
        for (int b = 0; b < 2; b++) begin
            r       = rand_r(1'b0);
            r_valid = 1'b1;
            tick();
        end
        rst_n        = 1'b0;
        req_ar_valid = '1;
        @(negedge clk);
        n_vec += 4;
        if (ar_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ar_valid: got %b expected 0", ar_valid); end
        if (req_ar_ready !== 4'b0) begin n_err++; $display("FAIL midrst_ar_ready: got %b expected 0000", req_ar_ready); end
        if (req_r_valid !== 4'b0) begin n_err++; $display("FAIL midrst_r_valid: got %b expected 0000", req_r_valid); end
        if (r_ready !== 1'b0) begin n_err++; $display("FAIL midrst_r_ready: got %b expected 0", r_ready); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec += 2;
        if (req_ar_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_regrant: got %b expected 0001", req_ar_ready); end
        if (r_ready !== 1'b0) begin n_err++; $display("FAIL midrst_fifo_empty: got %b expected 0", r_ready); end
        tick();
        req_ar_valid = '0;
        r_valid      = 1'b0;
    endtask

    task automatic test_random();
        int            ptr;
        logic          lock;
        int            lidx;
        int            route[$];
        logic [NR-1:0] pend;
        int            g;
        int            head;
        logic          exp_arv;
        logic          exp_rr;
        logic          full;
        logic          empty;
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_rv;
        do_reset();
        ptr  = 0;
        lock = 1'b0;
        lidx = 0;
        route.delete();
        pend = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    req_ar[i]   = rand_ar();
                    req_meta[i] = rand_meta();
                    pend[i]     = ($urandom_range(0, 1) == 1);
                end
            end
            req_ar_valid = pend;
            ar_ready     = ($urandom_range(0, 3) != 0);
            r_valid      = (cyc < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            r            = rand_r($urandom_range(0, 1) == 1);
            for (int i = 0; i < NR; i++) req_r_ready[i] = ($urandom_range(0, 3) != 0);

            full  = (route.size() == MO);
            empty = (route.size() == 0);
            head  = empty ? 0 : route[0];
            if (lock) begin
                g = lidx;
            end else begin
                g = -1;
                for (int k = 0; k < NR; k++) begin
                    int c;
                    c = (ptr + k) % NR;
                    if (g < 0 && req_ar_valid[c]) g = c;
                end
            end
            exp_arv = (g >= 0) && !full;
            exp_rdy = '0;
            if (exp_arv && ar_ready) exp_rdy[g] = 1'b1;
            exp_rv = '0;
            if (!empty && r_valid) exp_rv[head] = 1'b1;
            exp_rr = !empty && req_r_ready[head];

            @(negedge clk);
            n_vec += 4;
            if (ar_valid !== exp_arv) begin n_err++; $display("FAIL rnd_ar_valid cyc %0d: got %b expected %b", cyc, ar_valid, exp_arv); end
            if (req_ar_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ar_ready cyc %0d: got %b expected %b", cyc, req_ar_ready, exp_rdy); end
            if (req_r_valid !== exp_rv) begin n_err++; $display("FAIL rnd_r_valid cyc %0d: got %b expected %b", cyc, req_r_valid, exp_rv); end
            if (r_ready !== exp_rr) begin n_err++; $display("FAIL rnd_r_ready cyc %0d: got %b expected %b", cyc, r_ready, exp_rr); end
            if (exp_arv) begin
                n_vec += 2;
                if (ar !== req_ar[g]) begin n_err++; $display("FAIL rnd_ar cyc %0d: got %h expected %h", cyc, ar, req_ar[g]); end
                if (meta !== req_meta[g]) begin n_err++; $display("FAIL rnd_meta cyc %0d: got %h expected %h", cyc, meta, req_meta[g]); end
            end
            if (!empty && r_valid) begin
                n_vec++;
                if (req_r[head] !== r) begin n_err++; $display("FAIL rnd_r_data cyc %0d: got %h expected %h", cyc, req_r[head], r); end
            end

            if (r_valid && exp_rr && r.last) void'(route.pop_front());
            if (exp_arv && ar_ready) begin
                route.push_back(g);
                ptr     = (g + 1) % NR;
                lock    = 1'b0;
                pend[g] = 1'b0;
            end else if (exp_arv) begin
                lock = 1'b1;
                lidx = g;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_stall_lock();
        test_fifo_full();
        test_r_stall();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ar_cluster_scheduler
`default_nettype wire
